tx_cmd_sched: RTL and testbench

Command scheduler that shares the 2x4-cell UART transmitter among N requesters. Each requester offers one command (write cell, or send cell/row/column/all) through a valid/ready handshake; the block picks a winner round-robin, drives the transmitter's `d/row/col/action` pins for exactly one cycle, then tracks the transmitter's `busy` until the frame sequence ends. It sits between the host-side command sources and the transmitter, and is the only driver of the transmitter's command pins.

---
 rtl/tx_cmd_pkg.sv | 34 +++
 rtl/tx_cmd_sched_if.sv | 40 ++++
 rtl/tx_cmd_sched_rr_pick.sv | 35 +++
 rtl/tx_cmd_sched.sv | 154 +++++++++++++++
 tb/tb_tx_cmd_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_cmd_pkg.sv
// Shared encodings for the UART transmitter command scheduler: actions,
// scheduler states, error codes and small action-classification helpers.
package tx_cmd_pkg;

    localparam int ID_W = 3;

    localparam logic [3:0] ACT_WRITE     = 4'd1;
    localparam logic [3:0] ACT_SEND_CELL = 4'd2;
    localparam logic [3:0] ACT_SEND_ROW  = 4'd3;
    localparam logic [3:0] ACT_SEND_COL  = 4'd4;
    localparam logic [3:0] ACT_SEND_ALL  = 4'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_NO_START = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } sched_state_t;

    // Anything outside WRITE..SEND_ALL is rejected before reaching the transmitter.
    function automatic logic is_legal_action(input logic [3:0] action);
        return (action >= ACT_WRITE) && (action <= ACT_SEND_ALL);
    endfunction

    function automatic logic is_send(input logic [3:0] action);
        return (action >= ACT_SEND_CELL) && (action <= ACT_SEND_ALL);
    endfunction

endpackage

// File: rtl/tx_cmd_sched_if.sv
// Requester-side and transmitter-side signal bundle of the command scheduler.
// The scheduler uses the slave view; the host/transmitter side uses the master view.
interface tx_cmd_sched_if
    import tx_cmd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);

    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [4*N-1:0]   req_action;
    logic [N-1:0]     req_row;
    logic [2*N-1:0]   req_col;
    logic [W*N-1:0]   req_d;

    logic [3:0]       tx_action;
    logic             tx_row;
    logic [1:0]       tx_col;
    logic [W-1:0]     tx_d;
    logic             tx_busy;

    logic             done;
    logic [ID_W-1:0]  done_id;
    logic             err;
    logic [1:0]       err_code;

    modport slave (
        input  req_valid, req_action, req_row, req_col, req_d, tx_busy,
        output req_ready, tx_action, tx_row, tx_col, tx_d,
        output done, done_id, err, err_code
    );

    modport master (
        output req_valid, req_action, req_row, req_col, req_d, tx_busy,
        input  req_ready, tx_action, tx_row, tx_col, tx_d,
        input  done, done_id, err, err_code
    );

endinterface

// File: rtl/tx_cmd_sched_rr_pick.sv
// Combinational round-robin picker: the first valid requester after the last
// granted one wins, wrapping around N.
module tx_rr_pick
    import tx_cmd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    i_valid,
    input  logic [ID_W-1:0] i_last,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    int w_bestDist;

    // Priority distance of requester i is its offset past last+1 (mod N);
    // the valid requester with the smallest distance wins.
    always_comb begin
        o_grant    = '0;
        o_idx      = '0;
        o_any      = 1'b0;
        w_bestDist = N;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && (((i - int'(i_last) - 1 + 2 * N) % N) < w_bestDist)) begin
                w_bestDist = (i - int'(i_last) - 1 + 2 * N) % N;
                o_idx      = ID_W'(i);
                o_any      = 1'b1;
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_cmd_sched.sv
// Shares the 2x4-cell UART transmitter among N requesters: round-robin grant,
// one-cycle command issue, then busy tracking with start check and timeout.
module tx_cmd_sched
    import tx_cmd_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int TMO = 4096
) (
    input  logic           clk,
    input  logic           rst,
    tx_cmd_sched_if.slave  bus
);

    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

    sched_state_t     r_state;
    logic [ID_W-1:0]  r_lastIdx;
    logic [ID_W-1:0]  r_curIdx;
    logic [CNT_W-1:0] r_tmoCnt;
    logic [3:0]       r_txAction;
    logic             r_txRow;
    logic [1:0]       r_txCol;
    logic [W-1:0]     r_txD;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_errCode;
    logic [ID_W-1:0]  r_doneId;

    logic [N-1:0]     w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic             w_accept;
    logic [3:0]       w_action;
    logic             w_row;
    logic [1:0]       w_col;
    logic [W-1:0]     w_d;

    tx_rr_pick #(.N(N)) u_pick (
        .i_valid (bus.req_valid),
        .i_last  (r_lastIdx),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants happen only while idle and the transmitter is quiet; the ready
    // pulse must be combinational so the requester sees it in the accept cycle.
    assign w_accept      = (r_state == ST_IDLE) && !bus.tx_busy && w_any;
    assign bus.req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_action = '0;
        w_row    = 1'b0;
        w_col    = '0;
        w_d      = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_action = bus.req_action[4*i +: 4];
                w_row    = bus.req_row[i];
                w_col    = bus.req_col[2*i +: 2];
                w_d      = bus.req_d[W*i +: W];
            end
        end
    end

    // Row/col/data stay on the pins after issue so the transmitter can keep
    // reading them; only the action strobe returns to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lastIdx  <= ID_W'(N - 1);
            r_curIdx   <= '0;
            r_tmoCnt   <= '0;
            r_txAction <= '0;
            r_txRow    <= 1'b0;
            r_txCol    <= '0;
            r_txD      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errCode  <= ERR_NONE;
            r_doneId   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lastIdx <= w_idx;
                        r_curIdx  <= w_idx;
                        if (is_legal_action(w_action)) begin
                            r_txAction <= w_action;
                            r_txRow    <= w_row;
                            r_txCol    <= w_col;
                            r_txD      <= w_d;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_err     <= 1'b1;
                            r_errCode <= ERR_ILLEGAL;
                            r_doneId  <= w_idx;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_txAction <= '0;
                    if (is_send(r_txAction)) begin
                        r_state <= ST_WAIT_START;
                    end else begin
                        r_done   <= 1'b1;
                        r_doneId <= r_curIdx;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT_START: begin
                    if (bus.tx_busy) begin
                        r_tmoCnt <= '0;
                        r_state  <= ST_WAIT_DONE;
                    end else begin
                        r_err     <= 1'b1;
                        r_errCode <= ERR_NO_START;
                        r_doneId  <= r_curIdx;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_done   <= 1'b1;
                        r_doneId <= r_curIdx;
                        r_state  <= ST_IDLE;
                    end else if (r_tmoCnt == TMO_LAST) begin
                        r_err     <= 1'b1;
                        r_errCode <= ERR_TIMEOUT;
                        r_doneId  <= r_curIdx;
                        r_state   <= ST_IDLE;
                    end else if (r_tmoCnt != '1) begin
                        r_tmoCnt <= r_tmoCnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_action = r_txAction;
    assign bus.tx_row    = r_txRow;
    assign bus.tx_col    = r_txCol;
    assign bus.tx_d      = r_txD;
    assign bus.done      = r_done;
    assign bus.done_id   = r_doneId;
    assign bus.err       = r_err;
    assign bus.err_code  = r_errCode;

endmodule

// File: tb/tb_tx_cmd_sched.sv
// Directed bench for tx_cmd_sched with a busy-line transmitter stub and
// scoreboards of expected grants and completions.
module tb_tx_cmd_sched;
    import tx_cmd_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 16;

    typedef struct {
        bit isErr;
        int id;
        int code;
    } compl_t;

    logic clk;
    logic rst;

    tx_cmd_sched_if #(.N(N), .W(W)) bus ();

    tx_cmd_sched #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int busyMode;
    int busyLen;
    int busyCnt;
    logic sawSend;

    // Transmitter stand-in: raises busy the cycle after a SEND is issued and
    // holds it for busyLen cycles; mode 1 models a transmitter that never starts.
    initial begin
        bus.tx_busy = 1'b0;
        busyCnt = 0;
        forever begin
            @(negedge clk);
            sawSend = is_send(bus.tx_action);
            @(posedge clk);
            #1;
            if (rst) begin
                busyCnt = 0;
                bus.tx_busy = 1'b0;
            end else if (busyMode == 1) begin
                bus.tx_busy = 1'b0;
            end else begin
                if (sawSend) busyCnt = busyLen;
                if (busyCnt > 0) begin
                    bus.tx_busy = 1'b1;
                    busyCnt--;
                end else begin
                    bus.tx_busy = 1'b0;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int grantQ[$];
    compl_t complQ[$];
    logic [N-1:0] holdMask;
    bit fairMode;
    int fairGrants;
    int sinceReq1;

    logic [N-1:0]    sReady;
    logic [3:0]      sAction;
    logic            sRow;
    logic [1:0]      sCol;
    logic [W-1:0]    sD;
    logic            sBusy;
    logic            sDone;
    logic            sErr;
    logic [1:0]      sCode;
    logic [ID_W-1:0] sId;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] act, input logic row,
                                 input logic [1:0] col, input logic [W-1:0] d);
        bus.req_action[4*idx +: 4] = act;
        bus.req_row[idx]           = row;
        bus.req_col[2*idx +: 2]    = col;
        bus.req_d[W*idx +: W]      = d;
        bus.req_valid[idx]         = 1'b1;
    endtask

    task automatic expectGrant(input int id);
        grantQ.push_back(id);
    endtask

    task automatic expectDone(input int id);
        compl_t c;
        c.isErr = 1'b0; c.id = id; c.code = 0;
        complQ.push_back(c);
    endtask

    task automatic expectErr(input int id, input int code);
        compl_t c;
        c.isErr = 1'b1; c.id = id; c.code = code;
        complQ.push_back(c);
    endtask

    // One clock: snapshot outputs at the falling edge, score grants and
    // completions, then retire granted requests just after the rising edge.
    task automatic cycle();
        compl_t c;
        int g;
        @(negedge clk);
        sReady = bus.req_ready;  sAction = bus.tx_action; sRow = bus.tx_row;
        sCol = bus.tx_col;       sD = bus.tx_d;           sBusy = bus.tx_busy;
        sDone = bus.done;        sErr = bus.err;          sCode = bus.err_code;
        sId = bus.done_id;
        if (sAction != 4'd0) checkOutput("actionBusyOverlap", 32'(sBusy), 32'd0);
        if (sDone || sErr) begin
            checkOutput("doneErrExclusive", 32'(sDone & sErr), 32'd0);
            if (complQ.size() == 0) begin
                checkOutput("spuriousCompletion", {30'd0, sDone, sErr}, 32'd0);
            end else begin
                c = complQ.pop_front();
                checkOutput("complKind", {30'd0, sDone, sErr}, c.isErr ? 32'd1 : 32'd2);
                checkOutput("complId", 32'(sId), 32'(c.id));
                if (c.isErr) checkOutput("errCode", 32'(sCode), 32'(c.code));
            end
        end
        if (sReady != '0) begin
            if (grantQ.size() == 0) begin
                checkOutput("spuriousGrant", 32'(sReady), 32'd0);
            end else begin
                g = grantQ.pop_front();
                checkOutput("grant", 32'(sReady), 32'd1 << g);
            end
            if (fairMode) begin
                fairGrants++;
                if (sReady[1]) sinceReq1 = 0;
                else sinceReq1++;
                checkOutput("fairness", 32'(sinceReq1 <= 1), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~(sReady & ~holdMask);
        if (fairMode && sReady[1]) bus.req_valid[0] = 1'b1;
    endtask

    task automatic checkResetValues(input string ctx);
        checkOutput({ctx, ".req_ready"}, 32'(sReady), 32'd0);
        checkOutput({ctx, ".tx_action"}, 32'(sAction), 32'd0);
        checkOutput({ctx, ".tx_row"}, 32'(sRow), 32'd0);
        checkOutput({ctx, ".tx_col"}, 32'(sCol), 32'd0);
        checkOutput({ctx, ".tx_d"}, 32'(sD), 32'd0);
        checkOutput({ctx, ".done"}, 32'(sDone), 32'd0);
        checkOutput({ctx, ".err"}, 32'(sErr), 32'd0);
        checkOutput({ctx, ".err_code"}, 32'(sCode), 32'd0);
        checkOutput({ctx, ".done_id"}, 32'(sId), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_action = '0; bus.req_row = '0;
        bus.req_col = '0;   bus.req_d = '0;
        busyMode = 0; busyLen = 3; holdMask = '0; fairMode = 1'b0;
        fairGrants = 0; sinceReq1 = 0;

        cycle();
        cycle();
        checkResetValues("reset");
        rst = 1'b0;
        cycle();

        $display("[TB] single WRITE from requester 0");
        applyStimulus(0, ACT_WRITE, 1'b1, 2'd2, 8'hA5);
        expectGrant(0);
        expectDone(0);
        cycle();
        cycle();
        checkOutput("write.tx_action", 32'(sAction), 32'd1);
        checkOutput("write.tx_row", 32'(sRow), 32'd1);
        checkOutput("write.tx_col", 32'(sCol), 32'd2);
        checkOutput("write.tx_d", 32'(sD), 32'hA5);
        cycle();
        checkOutput("write.actionCleared", 32'(sAction), 32'd0);
        checkOutput("write.done", 32'(sDone), 32'd1);
        checkOutput("write.done_id", 32'(sId), 32'd0);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        $display("[TB] four simultaneous SEND_CELL requests");
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, ACT_SEND_CELL, 1'(i), 2'(i), 8'(8'h10 + i));
            expectGrant(i);
            expectDone(i);
        end
        for (int k = 0; k < 28; k++) cycle();

        $display("[TB] illegal action from requester 2");
        applyStimulus(2, 4'd7, 1'b0, 2'd1, 8'h33);
        expectGrant(2);
        expectErr(2, 1);
        cycle();
        cycle();
        checkOutput("illegal.err", 32'(sErr), 32'd1);
        checkOutput("illegal.err_code", 32'(sCode), 32'd1);
        checkOutput("illegal.done_id", 32'(sId), 32'd2);
        checkOutput("illegal.tx_action", 32'(sAction), 32'd0);

        $display("[TB] busy never rises after SEND_ROW");
        busyMode = 1;
        applyStimulus(1, ACT_SEND_ROW, 1'b1, 2'd0, 8'h44);
        expectGrant(1);
        expectErr(1, 2);
        for (int k = 0; k < 4; k++) cycle();
        checkOutput("noStart.err", 32'(sErr), 32'd1);
        checkOutput("noStart.err_code", 32'(sCode), 32'd2);
        busyMode = 0;
        cycle();

        $display("[TB] busy stuck high past the timeout");
        busyLen = 40;
        applyStimulus(3, ACT_SEND_COL, 1'b0, 2'd3, 8'h55);
        applyStimulus(0, ACT_WRITE, 1'b0, 2'd1, 8'h66);
        expectGrant(3);
        expectErr(3, 3);
        expectGrant(0);
        expectDone(0);
        for (int k = 0; k < 47; k++) begin
            cycle();
            if (k == 19) begin
                checkOutput("timeout.err", 32'(sErr), 32'd1);
                checkOutput("timeout.err_code", 32'(sCode), 32'd3);
                checkOutput("timeout.done_id", 32'(sId), 32'd3);
            end
            if (k >= 1 && sBusy) checkOutput("timeout.holdoff", 32'(sReady), 32'd0);
        end

        $display("[TB] reset during SEND_ALL");
        busyLen = 20;
        applyStimulus(2, ACT_SEND_ALL, 1'b1, 2'd3, 8'h5A);
        expectGrant(2);
        for (int k = 0; k < 5; k++) cycle();
        rst = 1'b1;
        cycle();
        checkResetValues("midReset");
        cycle();
        rst = 1'b0;
        busyLen = 3;
        applyStimulus(1, ACT_WRITE, 1'b0, 2'd0, 8'h01);
        applyStimulus(0, ACT_WRITE, 1'b1, 2'd1, 8'h02);
        expectGrant(0);
        expectDone(0);
        expectGrant(1);
        expectDone(1);
        for (int k = 0; k < 8; k++) cycle();

        $display("[TB] requester 1 held, requester 0 toggling");
        holdMask = 4'b0010;
        fairMode = 1'b1;
        fairGrants = 0;
        sinceReq1 = 0;
        applyStimulus(0, ACT_WRITE, 1'b0, 2'd2, 8'h77);
        applyStimulus(1, ACT_WRITE, 1'b1, 2'd3, 8'h88);
        for (int r = 0; r < 3; r++) begin
            expectGrant(0);
            expectDone(0);
            expectGrant(1);
            expectDone(1);
        end
        for (int k = 0; k < 40 && fairGrants < 6; k++) cycle();
        fairMode = 1'b0;
        holdMask = '0;
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) cycle();

        checkOutput("grantsOutstanding", 32'(grantQ.size()), 32'd0);
        checkOutput("completionsOutstanding", 32'(complQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
